// File: rtl/mult_operand_feeder.sv
// mult_operand_feeder
// Buffers operand pairs in a small FIFO and sequences them into a
// sequential multiplier: load strobe, fixed wait, product capture, then
// holds the result until the consumer takes it.

module mult_operand_feeder #(
  parameter int BIT_WIDTH   = 4,
  parameter int FIFO_DEPTH  = 2,
  parameter int LOAD_CYCLES = 2,
  parameter int WAIT_CYCLES = 2 * BIT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIT_WIDTH-1:0]   in_factor1,
  input  logic [BIT_WIDTH-1:0]   in_factor2,
  output logic                   mul_load,
  output logic                   mul_enable,
  output logic [BIT_WIDTH-1:0]   mul_factor1,
  output logic [BIT_WIDTH-1:0]   mul_factor2,
  input  logic [2*BIT_WIDTH-1:0] mul_product,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*BIT_WIDTH-1:0] out_product
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int MAX_CYC = (LOAD_CYCLES > WAIT_CYCLES) ? LOAD_CYCLES : WAIT_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]           state;
  logic [TMR_W-1:0]     timer;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     fifo_count;
  logic [BIT_WIDTH-1:0] fifo_f1 [FIFO_DEPTH];
  logic [BIT_WIDTH-1:0] fifo_f2 [FIFO_DEPTH];
  logic                 push;
  logic                 pop;

  // Handshake and pop decisions come only from registered state, so
  // in_ready never depends combinationally on in_valid and a pair pushed
  // into an empty FIFO is popped one cycle later at the earliest.
  assign in_ready   = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state == IDLE) && (fifo_count != '0);
  assign mul_load   = (state == LOAD);
  assign mul_enable = (state != IDLE);

  // Operand storage; entries are only meaningful while counted as valid.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_f1[wr_ptr] <= in_factor1;
      fifo_f2[wr_ptr] <= in_factor2;
    end
  end

  // Wrapping pointers and occupancy count; simultaneous push/pop cancels.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Operation sequencer: issue, load strobe, fixed wait, capture, hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      mul_factor1 <= '0;
      mul_factor2 <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            mul_factor1 <= fifo_f1[rd_ptr];
            mul_factor2 <= fifo_f2[rd_ptr];
            timer       <= '0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (timer == TMR_W'(LOAD_CYCLES - 1)) begin
            timer <= '0;
            state <= WAIT;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        WAIT: begin
          if (timer == TMR_W'(WAIT_CYCLES - 1)) begin
            timer       <= '0;
            out_product <= mul_product;
            out_valid   <= 1'b1;
            state       <= HOLD;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
